// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - M-mode CSR file, interrupt sync/priority, trap entry and mret redirect.
// Optional 64-bit mcycle at 0xB00/0xB80 when CSR_CYCLE_COUNTER_EN is defined.
module csr_trap_unit #(
  parameter int XLEN = 32,
  parameter int NUM_IRQ = 4,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               csr_en,
  input  logic [2:0]         csr_opcode,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [4:0]         uimm,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               ecall,
  input  logic               mret,
  input  logic               stall,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               illegal_csr,
  output logic               trap_taken,
  output logic [XLEN-1:0]    trap_pc,
  output logic               mie_bit
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
`ifdef CSR_CYCLE_COUNTER_EN
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
`endif

  logic [NUM_IRQ-1:0] sync1, sync2, mie_en, pend;
  logic               st_mie, st_mpie;
  logic [XLEN-1:0]    mtvec, mscratch, mepc, mcause;
  logic               hit, wr_op;
  logic [XLEN-1:0]    operand, wdata, base, irq_cause, irq_target;
  logic [4:0]         irq_idx;
  logic [5:0]         irq_code;
  logic               accept_ok, take_ecall, take_irq, take_mret, do_write;
`ifdef CSR_CYCLE_COUNTER_EN
  logic [63:0]        mcycle;
`endif

  assign mie_bit = st_mie;

  always_comb begin
    csr_rdata = '0;
    hit = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[3] = st_mie;
        csr_rdata[7] = st_mpie;
      end
      ADDR_MIE:      csr_rdata[16 +: NUM_IRQ] = mie_en;
      ADDR_MTVEC:    csr_rdata = mtvec;
      ADDR_MSCRATCH: csr_rdata = mscratch;
      ADDR_MEPC:     csr_rdata = mepc;
      ADDR_MCAUSE:   csr_rdata = mcause;
      ADDR_MIP:      csr_rdata[16 +: NUM_IRQ] = sync2;
`ifdef CSR_CYCLE_COUNTER_EN
      ADDR_MCYCLE:   csr_rdata = mcycle[XLEN-1:0];
      ADDR_MCYCLEH: begin
        if (XLEN == 32) csr_rdata = XLEN'(mcycle >> 32);
        else hit = 1'b0;
      end
`endif
      default:       hit = 1'b0;
    endcase
  end

  assign illegal_csr = csr_en & ~hit;

  assign operand = csr_opcode[2] ? XLEN'(uimm) : rs1_data;
  assign wr_op   = (csr_opcode[1:0] != 2'b00);

  always_comb begin
    case (csr_opcode[1:0])
      2'b01:   wdata = operand;
      2'b10:   wdata = csr_rdata | operand;
      2'b11:   wdata = csr_rdata & ~operand;
      default: wdata = csr_rdata;
    endcase
  end

  // Lowest-numbered pending and enabled line wins.
  assign pend = sync2 & mie_en;
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) irq_idx = 5'(i);
    end
  end

  assign irq_code   = 6'd16 + {1'b0, irq_idx};
  assign irq_cause  = {1'b1, (XLEN-1)'(irq_code)};
  assign base       = {mtvec[XLEN-1:2], 2'b00};
  assign irq_target = base + (mtvec[0] ? XLEN'({irq_code, 2'b00}) : '0);

  // The cycle carrying the redirect strobe never accepts a new event.
  assign accept_ok  = ~stall & ~trap_taken;
  assign take_ecall = ecall & accept_ok;
  assign take_irq   = ~ecall & accept_ok & st_mie & (|pend);
  assign take_mret  = mret & accept_ok & ~ecall & ~take_irq;
  assign do_write   = csr_en & ~stall & hit & wr_op & ~take_ecall & ~take_irq & ~take_mret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_en     <= '0;
      mtvec      <= MTVEC_RESET;
      mscratch   <= '0;
      mepc       <= '0;
      mcause     <= '0;
      trap_taken <= 1'b0;
      trap_pc    <= '0;
    end else begin
      sync1      <= irq_i;
      sync2      <= sync1;
      trap_taken <= 1'b0;
      if (take_ecall || take_irq) begin
        mepc       <= pc_i & ~XLEN'(3);
        st_mpie    <= st_mie;
        st_mie     <= 1'b0;
        mcause     <= take_ecall ? XLEN'(11) : irq_cause;
        trap_taken <= 1'b1;
        trap_pc    <= take_ecall ? base : irq_target;
      end else if (take_mret) begin
        st_mie     <= st_mpie;
        st_mpie    <= 1'b1;
        trap_taken <= 1'b1;
        trap_pc    <= mepc;
      end else if (do_write) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
          end
          ADDR_MIE:      mie_en   <= wdata[16 +: NUM_IRQ];
          ADDR_MTVEC:    mtvec    <= wdata;
          ADDR_MSCRATCH: mscratch <= wdata;
          ADDR_MEPC:     mepc     <= wdata & ~XLEN'(3);
          ADDR_MCAUSE:   mcause   <= wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_CYCLE_COUNTER_EN
  // A software write replaces its half and skips that cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle <= '0;
    end else if (do_write && csr_addr == ADDR_MCYCLE) begin
      if (XLEN == 32) mcycle[31:0] <= wdata[31:0];
      else mcycle <= 64'(wdata);
    end else if (do_write && csr_addr == ADDR_MCYCLEH) begin
      mcycle[63:32] <= wdata[31:0];
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - scoreboard bench for csr_trap_unit with a reference model.
module tb_csr_trap_unit;
  localparam int NUM_IRQ = 4;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_IRQ-1:0] irq_i = '0;
  logic csr_en = 1'b0;
  logic [2:0] csr_opcode = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] rs1_data = '0;
  logic [4:0] uimm = '0;
  logic [31:0] pc_i = '0;
  logic ecall = 1'b0, mret = 1'b0, stall = 1'b0;
  logic [31:0] csr_rdata, trap_pc;
  logic illegal_csr, trap_taken, mie_bit;

  csr_trap_unit #(.XLEN(32), .NUM_IRQ(NUM_IRQ), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .csr_en(csr_en), .csr_opcode(csr_opcode),
    .csr_addr(csr_addr), .rs1_data(rs1_data), .uimm(uimm), .pc_i(pc_i), .ecall(ecall),
    .mret(mret), .stall(stall), .csr_rdata(csr_rdata), .illegal_csr(illegal_csr),
    .trap_taken(trap_taken), .trap_pc(trap_pc), .mie_bit(mie_bit)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en; bit [31:0] rdata; bit ill; bit gie; bit tt; bit [31:0] tpc;
  } exp_t;
  exp_t sbq[$];
  int tests = 0, fails = 0;
  bit mon_on = 1'b0;
  bit [3:0] irq_drv = '0;

  // Architectural reference state
  bit m_gie, m_pie, m_tt;
  bit [31:0] m_ien, m_tvec, m_scr, m_epc, m_cause, m_tpc;
  bit [3:0] irq_hist1, irq_hist2;
  bit [63:0] m_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_gie = 0; m_pie = 0; m_tt = 0;
    m_ien = 0; m_tvec = MTVEC_RST; m_scr = 0; m_epc = 0; m_cause = 0; m_tpc = 0;
    irq_hist1 = 0; irq_hist2 = 0; m_cyc = 0;
  endfunction

  function automatic void mread(input bit [11:0] a, output bit ok, output bit [31:0] v);
    ok = 1; v = 0;
    case (a)
      12'h300: v = (32'(m_pie) << 7) | (32'(m_gie) << 3);
      12'h304: v = m_ien;
      12'h305: v = m_tvec;
      12'h340: v = m_scr;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'h344: v = 32'(irq_hist2) << 16;
`ifdef CSR_CYCLE_COUNTER_EN
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
`endif
      default: ok = 0;
    endcase
  endfunction

  // Drives one cycle, records what the DUT must show in it, then advances the model.
  task automatic step(input bit en = 0, input bit [2:0] op = 3'b000, input bit [11:0] a = 12'h000,
                      input bit [31:0] rs1 = 0, input bit [4:0] ui = 0, input bit [31:0] pc = 0,
                      input bit ec = 0, input bit mr = 0, input bit st = 0);
    exp_t e;
    bit ok, take_ok, cyc_wr, nxt_tt;
    bit [31:0] rv, opnd, nv;
    bit [3:0] pend;
    int code;
    csr_en = en; csr_opcode = op; csr_addr = a; rs1_data = rs1; uimm = ui;
    pc_i = pc; ecall = ec; mret = mr; stall = st; irq_i = irq_drv;
    mread(a, ok, rv);
    e.en = en; e.rdata = rv; e.ill = en && !ok; e.gie = m_gie; e.tt = m_tt; e.tpc = m_tpc;
    sbq.push_back(e);

    opnd = op[2] ? {27'b0, ui} : rs1;
    nv = (op[1:0] == 2'b01) ? opnd : (op[1:0] == 2'b10) ? (rv | opnd) : (rv & ~opnd);
    pend = irq_hist2 & m_ien[19:16];
    take_ok = !st && !m_tt;
    nxt_tt = 0; cyc_wr = 0; code = -1;
    for (int i = 0; i < NUM_IRQ; i++) if (pend[i]) begin code = 16 + i; break; end
    if (ec && take_ok) begin
      m_epc = pc & ~32'd3; m_pie = m_gie; m_gie = 0; m_cause = 11;
      nxt_tt = 1; m_tpc = m_tvec & ~32'd3;
    end else if (m_gie && code >= 0 && take_ok) begin
      m_epc = pc & ~32'd3; m_pie = m_gie; m_gie = 0; m_cause = 32'h8000_0000 | code;
      nxt_tt = 1; m_tpc = (m_tvec & ~32'd3) + (m_tvec[0] ? 32'(4 * code) : 32'd0);
    end else if (mr && take_ok) begin
      m_gie = m_pie; m_pie = 1; nxt_tt = 1; m_tpc = m_epc;
    end else if (en && !st && ok) begin
      case (a)
        12'h300: begin m_gie = nv[3]; m_pie = nv[7]; end
        12'h304: m_ien = nv & 32'h000F_0000;
        12'h305: m_tvec = nv;
        12'h340: m_scr = nv;
        12'h341: m_epc = nv & ~32'd3;
        12'h342: m_cause = nv;
        12'hB00: begin m_cyc[31:0] = nv; cyc_wr = 1; end
        12'hB80: begin m_cyc[63:32] = nv; cyc_wr = 1; end
        default: ;
      endcase
    end
    if (!cyc_wr) m_cyc = m_cyc + 1;
    m_tt = nxt_tt;
    irq_hist2 = irq_hist1; irq_hist1 = irq_drv;
    @(posedge clk); #1;
  endtask

  // Stalled reads expose the old value without any architectural side effect.
  task automatic rd(input bit [11:0] a);
    step(1, 3'b010, a, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic wr(input bit [11:0] a, input bit [31:0] v);
    step(1, 3'b001, a, v);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_underflow: got empty queue, expected an entry at %0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("trap_taken", trap_taken, e.tt);
        if (e.tt) check("trap_pc", trap_pc, e.tpc);
        check("mie_bit", mie_bit, e.gie);
        if (e.en) begin
          check("csr_rdata", csr_rdata, e.rdata);
          check("illegal_csr", illegal_csr, e.ill);
        end else begin
          check("illegal_idle", illegal_csr, 0);
        end
      end
    end
  end

  bit [11:0] addrs [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                            12'h344, 12'h7C0, 12'hB00, 12'hB80, 12'h000};
  bit [2:0] ops [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    csr_addr = 12'h305;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trap_taken", trap_taken, 0);
    check("rst_trap_pc", trap_pc, 0);
    check("rst_mie_bit", mie_bit, 0);
    check("rst_mtvec", csr_rdata, MTVEC_RST);
    rst = 1'b0;
    model_reset();
    mon_on = 1'b1;

    foreach (addrs[i]) rd(addrs[i]);

    wr(12'h340, 32'hA5A5_0F0F);
    step(1, 3'b010, 12'h340, 32'h0000_F000);
    step(1, 3'b111, 12'h340, 0, 5'h0F);
    rd(12'h340);

    // Direct-mode interrupt on line 1
    wr(12'h304, 32'h0002_0000);
    wr(12'h305, 32'h0000_0100);
    step(1, 3'b110, 12'h300, 0, 5'd8);
    irq_drv = 4'b0010;
    repeat (3) step(0, 0, 0, 0, 0, 32'h2000);
    check("irq1_tt", trap_taken, 1);
    check("irq1_tpc", trap_pc, 32'h100);
    irq_drv = 4'b0000;
    rd(12'h341); rd(12'h342); rd(12'h300);

    // Vectored mode, lines 0 and 2 raised together
    wr(12'h304, 32'h0005_0000);
    wr(12'h305, 32'h0000_0101);
    repeat (2) step();
    step(1, 3'b110, 12'h300, 0, 5'd8);
    irq_drv = 4'b0101;
    repeat (3) step(0, 0, 0, 0, 0, 32'h3000);
    check("irq0_tt", trap_taken, 1);
    check("irq0_tpc", trap_pc, 32'h140);
    irq_drv = 4'b0000;
    rd(12'h342);

    // ecall beats a same-cycle CSR write, then mret returns
    repeat (3) step();
    step(1, 3'b110, 12'h300, 0, 5'd8);
    step(1, 3'b001, 12'h340, 32'hDEAD_BEEF, 0, 32'h44, 1);
    check("ecall_tpc", trap_pc, 32'h100);
    rd(12'h340); rd(12'h342); rd(12'h341); rd(12'h300);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("mret_tt", trap_taken, 1);
    check("mret_tpc", trap_pc, 32'h44);
    rd(12'h300);

    for (int k = 0; k < 2; k++) begin
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'h0);
      step();
      rd(k == 0 ? 12'hB00 : 12'hB80);
    end

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(9) == 0) irq_drv = 4'($urandom);
      step($urandom_range(9) < 6, ops[$urandom_range(5)], addrs[$urandom_range(10)] | 12'($urandom_range(1) == 0 ? 0 : $urandom_range(4095)) & 12'h0,
           $urandom, 5'($urandom), $urandom & 32'hFFFF_FFFC,
           $urandom_range(24) == 0, $urandom_range(24) == 0, $urandom_range(4) == 0);
    end
    irq_drv = 4'b0000;
    repeat (4) step();

    // Async reset while the redirect strobe is high
    step(0, 0, 0, 0, 0, 32'h88, 1);
    check("pre_rst_tt", trap_taken, 1);
    mon_on = 1'b0;
    sbq.delete();
    #1 rst = 1'b1;
    #1;
    check("async_rst_tt", trap_taken, 0);
    check("async_rst_tpc", trap_pc, 0);
    check("async_rst_mie", mie_bit, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    mon_on = 1'b1;
    rd(12'h342); rd(12'h341); rd(12'h300);
    step();

    mon_on = 1'b0;
    check("sb_drain", 64'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Parametrised machine-mode CSR unit that supersedes the fixed 32-bit csr wrapper. It holds the M-mode CSRs and decodes all six Zicsr operations. It also synchronises and prioritises NUM_IRQ interrupt lines, sequences trap entry (ecall or interrupt) and mret, and drives a registered redirect to the fetch stage.

Parameters:
XLEN, 32, data width of every CSR and datapath port (32 or 64)
NUM_IRQ, 4, number of interrupt lines (1..16), mapped to mie/mip bits [16+NUM_IRQ-1:16]
MTVEC_RESET, 0, reset value of mtvec

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
irq_i  in  NUM_IRQ  level interrupt requests, asynchronous to clk
csr_en  in  1  CSR instruction valid this cycle
csr_opcode  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
csr_addr  in  12  CSR address
rs1_data  in  XLEN  source operand for register forms
uimm  in  5  zero-extended immediate for I forms
pc_i  in  XLEN  PC of the instruction in execute
ecall  in  1  ecall in execute
mret  in  1  mret in execute
stall  in  1  pipeline frozen; no architectural CSR update
csr_rdata  out  XLEN  old value of the addressed CSR (combinational)
illegal_csr  out  1  csr_en with an unimplemented address
trap_taken  out  1  registered one-cycle redirect strobe
trap_pc  out  XLEN  redirect target, valid while trap_taken=1
mie_bit  out  1  mstatus.MIE

Behaviour:
- Reset: mstatus=0 (MIE bit3=0, MPIE bit7=0), mie=0, mtvec=MTVEC_RESET, mscratch=0, mepc=0, mcause=0, mcycle=0, sync flops=0, trap_taken=0, trap_pc=0. csr_rdata and illegal_csr then follow the reset state.
- CSR map: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x344 mip (read-only; writes ignored).
- Writable-bit masks:
  - mstatus: bits 3 and 7 only.
  - mie: bits [16+NUM_IRQ-1:16] only.
  - mepc: bits [1:0] forced to 0.
- Unknown address with csr_en=1: illegal_csr=1, csr_rdata=0, no state change.
- Write value: operand = rs1_data for funct3[2]=0, else {zeros,uimm}. RW writes operand, RS writes old|operand, RC writes old&~operand. The update lands on the next clk edge when csr_en=1 and stall=0.
- mip[16+i] = irq_i[i] after a 2-flop synchroniser, giving 2 cycles of latency. Lines are level-sensitive and not latched; dropping the line clears pending.
- Interrupt accept condition: MIE=1, |(mip&mie)=1, stall=0, trap_taken=0. The lowest index wins.
- Priority within a cycle: ecall > interrupt > mret > CSR write. A trap suppresses a same-cycle CSR write. mret with a pending enabled interrupt takes mret first; the interrupt is accepted in a later cycle once MIE has been restored.
- Trap entry, at the next edge:
  - mepc <= pc_i; MPIE <= MIE; MIE <= 0.
  - mcause: interrupt -> {1'b1, zeros, (16+i)}; ecall -> 11.
  - trap_taken <= 1.
  - trap_pc <= {mtvec[XLEN-1:2],2'b00}. If mtvec[0]=1 and the trap is an interrupt, add 4*(16+i).
- mret, at the next edge: MIE <= MPIE; MPIE <= 1; trap_taken <= 1; trap_pc <= mepc.
- trap_taken is high for exactly one cycle. The cycle after it is blocked for new accepts, which prevents a double take.
- stall=1: CSR, trap and mret state frozen. Only the synchroniser and mcycle advance. trap_taken still clears.
- Async rst mid-trap: all state returns to reset values immediately and no strobe is emitted.

Optional Feature:
- Macro: CSR_CYCLE_COUNTER_EN.
- Defined: 64-bit mcycle increments every clk (wraps 2^64-1 -> 0).
  - Reads: 0xB00 returns the low XLEN bits; for XLEN=32, 0xB80 returns the high 32 bits.
  - Writes to either address replace that half. A write takes priority over the increment in that cycle.
- Undefined: 0xB00/0xB80 are unimplemented (illegal_csr=1); no counter flops are built.

Test Plan:
- Reset, then read each CSR -> all 0, mtvec=MTVEC_RESET, illegal_csr=0; read 0x7C0 -> illegal_csr=1, csr_rdata=0.
- CSRRW 0x340 with rs1=0xA5A5_0F0F, then CSRRS with 0x0000_F000, then CSRRCI uimm=0x0F -> reads 0xA5A5_0F0F, then 0xA5A5_FF0F, final value 0xA5A5_FF00.
- Set mie bit17 and MIE=1, mtvec=0x100 (direct); raise irq_i[1] at pc_i=0x2000 -> trap_taken pulses 3 cycles later with trap_pc=0x100, mepc=0x2000, mcause=0x8000_0011, MIE=0, MPIE=1.
- mtvec=0x101 (vectored), irq_i[0] and irq_i[2] both enabled and raised -> index 0 wins, trap_pc=0x140, mcause low bits=16.
- ecall and a csr_en write to mscratch in the same cycle at pc_i=0x44 -> mcause=11, mepc=0x44, mscratch unchanged; then mret -> trap_pc=0x44, MIE restored.
- With CSR_CYCLE_COUNTER_EN: write 0xB00=0xFFFF_FFFF, 0xB80=0 -> two cycles later 0xB80 reads 1 and 0xB00 reads 0. Without the macro: 0xB00 reads as illegal.
